// File: rtl/toast_entry.sv
// Keypad entry controller: debounces key presses, builds a decimal edit buffer, commits it to the timer.
// Latency: a press acts DB_CYCLES+2 cycles after raw kphit rises; write is held until write_ack is seen.
module toast_entry #(
    parameter int DB_CYCLES = 20,
    parameter int MAX_TIME  = 999,
    parameter int MAX_DC    = 100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       kphit,
    input  logic [3:0] num,
    input  logic       write_ack,
    output logic [9:0] Time,
    output logic [7:0] DC,
    output logic [9:0] entry,
    output logic       mode,
    output logic       write,
    output logic       start,
    output logic       stop
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        ACT,
        WAIT_REL,
        DB_REL
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    key_q, key_d;
    logic [9:0]    entry_q, entry_d;
    logic          mode_q, mode_d;
    logic [9:0]    time_q, time_d;
    logic [7:0]    dc_q, dc_d;
    logic          write_q, write_d;
    logic          start_q, start_d;
    logic          stop_q, stop_d;

    logic          kphit_s1_q, kphit_s2_q;
    logic [3:0]    num_s1_q, num_s2_q;

    logic [13:0]   digit_val;
    logic [13:0]   limit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kphit_s1_q <= 1'b0;
            kphit_s2_q <= 1'b0;
            num_s1_q   <= 4'd0;
            num_s2_q   <= 4'd0;
        end else begin
            kphit_s1_q <= kphit;
            kphit_s2_q <= kphit_s1_q;
            num_s1_q   <= num;
            num_s2_q   <= num_s1_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_q   <= 4'd0;
            entry_q <= 10'd0;
            mode_q  <= 1'b0;
            time_q  <= 10'd0;
            dc_q    <= 8'd0;
            write_q <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            entry_q <= entry_d;
            mode_q  <= mode_d;
            time_q  <= time_d;
            dc_q    <= dc_d;
            write_q <= write_d;
            start_q <= start_d;
            stop_q  <= stop_d;
        end
    end

    // 14 bits holds 999*10+9 without overflow before clamping.
    assign digit_val = ({4'd0, entry_q} * 14'd10) + {10'd0, key_q};
    assign limit     = mode_q ? 14'(MAX_DC) : 14'(MAX_TIME);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        entry_d = entry_q;
        mode_d  = mode_q;
        time_d  = time_q;
        dc_d    = dc_q;
        write_d = write_q;
        start_d = 1'b0;
        stop_d  = 1'b0;

        if (write_q && write_ack) begin
            write_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (kphit_s2_q) begin
                    cnt_d   = CW'(1);
                    state_d = DB_PRESS;
                end
            end
            DB_PRESS: begin
                if (!kphit_s2_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    key_d   = num_s2_q;
                    state_d = ACT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ACT: begin
                state_d = WAIT_REL;
                case (key_q)
                    4'd10: begin
                        mode_d  = 1'b0;
                        entry_d = 10'd0;
                    end
                    4'd11: begin
                        mode_d  = 1'b1;
                        entry_d = 10'd0;
                    end
                    4'd12: entry_d = 10'd0;
                    4'd13: begin
                        // A commit already in flight swallows the key; an ack this cycle only retires the old one.
                        if (!write_q) begin
                            if (mode_q) begin
                                dc_d = entry_q[7:0];
                            end else begin
                                time_d = entry_q;
                            end
                            write_d = 1'b1;
                            entry_d = 10'd0;
                        end
                    end
                    4'd14: begin
                        if ((time_q != 10'd0) && !write_q) begin
                            start_d = 1'b1;
                        end
                    end
                    4'd15: stop_d = 1'b1;
                    default: begin
                        entry_d = (digit_val > limit) ? limit[9:0] : digit_val[9:0];
                    end
                endcase
            end
            WAIT_REL: begin
                if (!kphit_s2_q) begin
                    cnt_d   = CW'(1);
                    state_d = DB_REL;
                end
            end
            DB_REL: begin
                if (kphit_s2_q) begin
                    state_d = WAIT_REL;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Time  = time_q;
    assign DC    = dc_q;
    assign entry = entry_q;
    assign mode  = mode_q;
    assign write = write_q;
    assign start = start_q;
    assign stop  = stop_q;

endmodule

// File: tb/tb_toast_entry.sv
// Bench for toast_entry: keypad presses are scored against an arithmetic model through an event queue.
module tb_toast_entry;

    localparam int DB = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       kphit = 1'b0;
    logic [3:0] num = 4'd0;
    logic       write_ack = 1'b0;
    logic [9:0] Time;
    logic [7:0] DC;
    logic [9:0] entry;
    logic       mode;
    logic       write;
    logic       start;
    logic       stop;

    always #5 clk = ~clk;

    toast_entry #(.DB_CYCLES(DB), .MAX_TIME(999), .MAX_DC(100)) dut (
        .clk(clk), .reset_n(reset_n), .kphit(kphit), .num(num), .write_ack(write_ack),
        .Time(Time), .DC(DC), .entry(entry), .mode(mode), .write(write),
        .start(start), .stop(stop)
    );

    typedef enum int {EV_ENTRY, EV_WRISE, EV_WFALL, EV_START, EV_STOP} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       a;
        int       b;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    int  m_entry = 0, m_mode = 0, m_time = 0, m_dc = 0;
    bit  m_write = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    function automatic void push(ev_kind_t k, int a, int b);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endfunction

    // Reference behaviour of one accepted key press.
    function automatic void model_key(int k);
        int old_e = m_entry;
        int old_m = m_mode;
        int lim;
        bit wr = 0, st = 0, sp = 0;
        if (k <= 9) begin
            lim = m_mode ? 100 : 999;
            m_entry = m_entry * 10 + k;
            if (m_entry > lim) m_entry = lim;
        end else if (k == 10) begin
            m_mode = 0; m_entry = 0;
        end else if (k == 11) begin
            m_mode = 1; m_entry = 0;
        end else if (k == 12) begin
            m_entry = 0;
        end else if (k == 13) begin
            if (!m_write) begin
                if (m_mode == 1) m_dc = m_entry; else m_time = m_entry;
                m_entry = 0;
                m_write = 1;
                wr = 1;
            end
        end else if (k == 14) begin
            st = (m_time != 0) && !m_write;
        end else begin
            sp = 1;
        end
        if (m_entry != old_e || m_mode != old_m) push(EV_ENTRY, m_entry, m_mode);
        if (wr) push(EV_WRISE, m_time, m_dc);
        if (st) push(EV_START, 0, 0);
        if (sp) push(EV_STOP, 0, 0);
    endfunction

    task automatic pop_cmp(input ev_kind_t k, input int a, input int b);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind=%0d a=%0d b=%0d, want no event", k, a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.a != a || e.b != b) begin
                n_err++;
                $display("FAIL event: got kind=%0d a=%0d b=%0d, want kind=%0d a=%0d b=%0d",
                         k, a, b, e.kind, e.a, e.b);
            end
        end
    endtask

    logic [9:0] p_entry = '0, p_time = '0;
    logic [7:0] p_dc = '0;
    logic       p_mode = 1'b0, p_write = 1'b0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (entry !== p_entry || mode !== p_mode) pop_cmp(EV_ENTRY, int'(entry), int'(mode));
            if (write && !p_write) pop_cmp(EV_WRISE, int'(Time), int'(DC));
            else if (Time !== p_time || DC !== p_dc)
                chk("time_dc_stable", {14'd0, Time, DC}, {14'd0, p_time, p_dc});
            if (!write && p_write) pop_cmp(EV_WFALL, 0, 0);
            if (start) pop_cmp(EV_START, 0, 0);
            if (stop) pop_cmp(EV_STOP, 0, 0);
        end
        p_entry = entry;
        p_mode  = mode;
        p_time  = Time;
        p_dc    = DC;
        p_write = write;
    end

    task automatic glitch(input logic [3:0] k, input int n);
        @(negedge clk);
        num   = k;
        kphit = 1'b1;
        repeat (n) @(negedge clk);
        kphit = 1'b0;
    endtask

    task automatic press(input logic [3:0] k, input int hold, input bit rel_bounce);
        model_key(int'(k));
        @(negedge clk);
        num   = k;
        kphit = 1'b1;
        repeat (hold) @(negedge clk);
        kphit = 1'b0;
        if (rel_bounce) begin
            repeat (3) @(negedge clk);
            kphit = 1'b1;
            repeat ($urandom_range(1, DB - 1)) @(negedge clk);
            kphit = 1'b0;
        end
        repeat (DB + 6) @(negedge clk);
    endtask

    task automatic key(input int k);
        press(4'(k), DB + 6, 1'b0);
    endtask

    task automatic do_ack();
        bit was = m_write;
        if (m_write) begin
            push(EV_WFALL, 0, 0);
            m_write = 0;
        end
        @(negedge clk);
        write_ack = 1'b1;
        @(posedge clk);
        #1;
        if (was) chk("write_falls_on_ack_edge", write, 0);
        @(negedge clk);
        write_ack = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_Time", Time, 0);
        chk("rst_DC", DC, 0);
        chk("rst_entry", entry, 0);
        chk("rst_mode", mode, 0);
        chk("rst_write", write, 0);
        chk("rst_start", start, 0);
        chk("rst_stop", stop, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Start with Time=0 must be ignored, then commit 30 and start/stop.
        key(14);
        key(10); key(3); key(0); key(13);
        do_ack();
        chk("commit_Time30", Time, 30);
        key(14);
        key(15);
        chk("Time_after_stop", Time, 30);

        key(10); key(1); key(2); key(0); key(13);
        chk("write_pending", write, 1);
        do_ack();
        chk("Time120", Time, 120);
        chk("entry_after_D", entry, 0);
        chk("mode_time", mode, 0);

        key(11); key(9); key(9); key(9);
        chk("dc_clamp", entry, 100);
        key(13);
        do_ack();
        chk("DC100", DC, 100);
        chk("Time_kept", Time, 120);
        chk("mode_duty", mode, 1);

        key(10);
        for (int i = 0; i < 3; i++) begin
            glitch(4'd5, DB - 1);
        end
        press(4'd5, 500, 1'b0);
        chk("bounce_one_digit", entry, 5);

        key(10); key(4); key(13);
        key(10); key(7); key(13);
        chk("second_D_ignored_Time", Time, 4);
        chk("second_D_write_held", write, 1);
        do_ack();
        chk("write_cleared", write, 0);

        key(10); key(6); key(13);
        @(negedge clk);
        num   = 4'd1;
        kphit = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_Time", Time, 0);
        chk("mid_rst_DC", DC, 0);
        chk("mid_rst_entry", entry, 0);
        chk("mid_rst_write", write, 0);
        chk("mid_rst_mode", mode, 0);
        chk("mid_rst_start_stop", {start, stop}, 0);
        chk("queue_empty_at_reset", exp_q.size(), 0);
        exp_q.delete();
        m_entry = 0; m_mode = 0; m_time = 0; m_dc = 0; m_write = 0;
        @(negedge clk);
        kphit = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        key(8);
        chk("post_reset_press", entry, 8);

        for (int i = 0; i < 80; i++) begin
            int k = $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) glitch(4'(k), $urandom_range(1, DB - 1));
            press(4'(k), $urandom_range(DB + 1, DB + 40), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) do_ack();
        end
        do_ack();

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
